if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000000: value driven on Instruction_Out during reset and bubbles.
REQ-003 Port CLOCK  input  1: single clock; all state updates on its rising edge.
REQ-004 Port RESET_N  input  1: reset, asynchronous and active-low.
REQ-005 Port Stall_In  input  1: downstream IF/ID register cannot accept this cycle.
REQ-006 Port Branch_Taken_In  input  1: redirect request from a later stage.
REQ-007 Port Branch_Target_In  input  32: redirect target address.
REQ-008 Port IMem_Req_Out  output  1: instruction-memory request.
REQ-009 Port IMem_Addr_Out  output  32: fetch address; equals PC whenever IMem_Req_Out=1.
REQ-010 Port IMem_Ready_In  input  1: memory completes the transfer; data valid in the same cycle.
REQ-011 Port IMem_Data_In  input  32: fetched instruction word.
REQ-012 Port Instruction_Out  output  32: registered instruction to IF/ID.
REQ-013 Port PCPlus4_Out  output  32: registered address of delivered instruction + 4.
REQ-014 Port Valid_Out  output  1: Instruction_Out/PCPlus4_Out hold a real instruction.
REQ-015 Port Fetch_Count_Out  output  32: count of instructions delivered since reset.

Function
REQ-016 Internal state: PC (32), skid buffer {Skid_Instr, Skid_PC4} (64), FSM with states FETCH and HOLD.
REQ-017 A transfer completes only in a cycle where IMem_Req_Out=1 and IMem_Ready_In=1; one transfer per cycle maximum; no outstanding transactions exist after a non-completing cycle.
REQ-018 FETCH: IMem_Req_Out=1, IMem_Addr_Out=PC; Req and Addr held stable until completion, stall or redirect.
REQ-019 FETCH, transfer completes, Stall_In=0, no redirect: Instruction_Out<=IMem_Data_In, PCPlus4_Out<=PC+4, Valid_Out<=1, PC<=PC+4, Fetch_Count_Out+=1, remain FETCH (back-to-back fetch, latency 1 cycle from completion to outputs).
REQ-020 FETCH, no completion, Stall_In=0: Valid_Out<=0, Instruction_Out<=NOP_INSTR (bubble); PC unchanged.
REQ-021 FETCH, Stall_In=1: Instruction_Out, PCPlus4_Out, Valid_Out hold; a completing transfer is captured into the skid buffer, PC<=PC+4, next state HOLD.
REQ-022 HOLD: IMem_Req_Out=0; while Stall_In=1 all outputs and skid hold; when Stall_In=0, outputs<=skid contents, Valid_Out<=1, Fetch_Count_Out+=1, next state FETCH.
REQ-023 Redirect (Branch_Taken_In=1) has priority over every other event in any state: PC<=Branch_Target_In with bits[1:0] forced to 0, skid discarded, Valid_Out<=0, Instruction_Out<=NOP_INSTR, next state FETCH, Fetch_Count_Out unchanged.
REQ-024 Redirect coincident with a completing transfer: fetched data is discarded, never delivered.
REQ-025 Redirect coincident with Stall_In=1: flush takes effect regardless of stall.
REQ-026 PC+4 and Fetch_Count_Out wrap modulo 2^32 without error.
REQ-027 IMem_Req_Out is driven 0 for the cycle in which a redirect is sampled; fetching from the new PC starts the next cycle.

Reset
REQ-028 RESET_N=0 immediately forces: PC=RESET_PC, state FETCH, Instruction_Out=NOP_INSTR, PCPlus4_Out=0, Valid_Out=0, Fetch_Count_Out=0, skid cleared, IMem_Req_Out=0.
REQ-029 Reset asserted mid-transfer or mid-HOLD abandons all state; after deassertion, first request is issued at RESET_PC on the next rising edge.

Verification
REQ-030 Reset release, IMem_Ready_In=1 every cycle, data=addr^32'hA5A5A5A5 -> Instruction_Out sequence for PC 0,4,8; PCPlus4_Out 4,8,12; Valid_Out=1 every cycle; Fetch_Count_Out=3.
REQ-031 IMem_Ready_In asserted every 3rd cycle -> two bubble cycles (Valid_Out=0, NOP) between deliveries; IMem_Addr_Out stable during wait.
REQ-032 Stall_In=1 for 4 cycles while transfer at PC=8 completes -> outputs frozen, IMem_Req_Out=0 in HOLD; on release word at 8 delivered with PCPlus4_Out=12, next request addr 12.
REQ-033 Branch_Taken_In=1, target 32'h00000103, same cycle as completion at PC=16 -> word at 16 never delivered; next IMem_Addr_Out=32'h00000100; Valid_Out=0 one cycle.
REQ-034 Redirect during HOLD with Stall_In=1 -> skid discarded, Valid_Out=0, FETCH at target; Fetch_Count_Out unchanged.
REQ-035 RESET_N pulsed low mid-wait, asynchronous to CLOCK -> all outputs at reset values before next edge; PC=RESET_PC; PC=32'hFFFFFFFC fetch -> PCPlus4_Out=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: drives a single-beat instruction memory port and feeds the IF/ID register.
// A one-entry skid buffer keeps a word that completes while IF/ID is stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        Stall_In,
  input  logic        Branch_Taken_In,
  input  logic [31:0] Branch_Target_In,
  output logic        IMem_Req_Out,
  output logic [31:0] IMem_Addr_Out,
  input  logic        IMem_Ready_In,
  input  logic [31:0] IMem_Data_In,
  output logic [31:0] Instruction_Out,
  output logic [31:0] PCPlus4_Out,
  output logic        Valid_Out,
  output logic [31:0] Fetch_Count_Out
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] skid_instr_reg;
  logic [31:0] skid_pc4_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc4_reg;
  logic [31:0] count_reg;
  logic        valid_reg;
  logic        armed_reg;

  logic [31:0] pc_plus4;
  logic        xfer_done;

  assign pc_plus4 = pc_reg + 32'd4;

  // armed_reg keeps the request low until the first edge after reset release;
  // a redirect in flight suppresses the request combinationally.
  assign IMem_Req_Out  = armed_reg && (state_reg == FETCH) && !Branch_Taken_In;
  assign IMem_Addr_Out = pc_reg;
  assign xfer_done     = IMem_Req_Out && IMem_Ready_In;

  assign Instruction_Out = instr_reg;
  assign PCPlus4_Out     = pc4_reg;
  assign Valid_Out       = valid_reg;
  assign Fetch_Count_Out = count_reg;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      skid_instr_reg <= 32'd0;
      skid_pc4_reg   <= 32'd0;
      instr_reg      <= NOP_INSTR;
      pc4_reg        <= 32'd0;
      count_reg      <= 32'd0;
      valid_reg      <= 1'b0;
      armed_reg      <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
      if (Branch_Taken_In) begin
        // Flush wins over stall, completion and any buffered word.
        pc_reg         <= Branch_Target_In & ~32'd3;
        skid_instr_reg <= 32'd0;
        skid_pc4_reg   <= 32'd0;
        instr_reg      <= NOP_INSTR;
        valid_reg      <= 1'b0;
        state_reg      <= FETCH;
      end else begin
        case (state_reg)
          FETCH: begin
            if (Stall_In) begin
              if (xfer_done) begin
                skid_instr_reg <= IMem_Data_In;
                skid_pc4_reg   <= pc_plus4;
                pc_reg         <= pc_plus4;
                state_reg      <= HOLD;
              end
            end else if (xfer_done) begin
              instr_reg <= IMem_Data_In;
              pc4_reg   <= pc_plus4;
              valid_reg <= 1'b1;
              pc_reg    <= pc_plus4;
              count_reg <= count_reg + 32'd1;
            end else begin
              instr_reg <= NOP_INSTR;
              valid_reg <= 1'b0;
            end
          end
          HOLD: begin
            if (!Stall_In) begin
              instr_reg <= skid_instr_reg;
              pc4_reg   <= skid_pc4_reg;
              valid_reg <= 1'b1;
              count_reg <= count_reg + 32'd1;
              state_reg <= FETCH;
            end
          end
          default: state_reg <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage against a queue-based reference model.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h00000000;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] KEY    = 32'hA5A5A5A5;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        Stall_In = 1'b0;
  logic        Branch_Taken_In = 1'b0;
  logic [31:0] Branch_Target_In = 32'd0;
  logic        IMem_Ready_In = 1'b0;
  logic [31:0] IMem_Data_In;
  logic        IMem_Req_Out;
  logic [31:0] IMem_Addr_Out;
  logic [31:0] Instruction_Out;
  logic [31:0] PCPlus4_Out;
  logic        Valid_Out;
  logic [31:0] Fetch_Count_Out;

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .Stall_In(Stall_In),
    .Branch_Taken_In(Branch_Taken_In), .Branch_Target_In(Branch_Target_In),
    .IMem_Req_Out(IMem_Req_Out), .IMem_Addr_Out(IMem_Addr_Out),
    .IMem_Ready_In(IMem_Ready_In), .IMem_Data_In(IMem_Data_In),
    .Instruction_Out(Instruction_Out), .PCPlus4_Out(PCPlus4_Out),
    .Valid_Out(Valid_Out), .Fetch_Count_Out(Fetch_Count_Out)
  );

  always #5 CLOCK = ~CLOCK;

  // Memory image: every word is its own address xor a key.
  assign IMem_Data_In = IMem_Addr_Out ^ KEY;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  bit          m_valid, m_started;
  logic [63:0] held[$];
  bit          p_br, p_stall, p_ready, p_req;
  logic [31:0] p_tgt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = NOP; m_pc4 = 32'd0; m_valid = 0;
    m_count = 32'd0; m_started = 0; held.delete();
  endtask

  task automatic model_edge();
    bit done;
    logic [63:0] w;
    done = p_req && p_ready;
    m_started = 1;
    if (p_br) begin
      m_pc = p_tgt & ~32'd3; held.delete(); m_valid = 0; m_instr = NOP;
    end else if (held.size() != 0) begin
      if (!p_stall) begin
        w = held.pop_front();
        m_instr = w[63:32]; m_pc4 = w[31:0]; m_valid = 1; m_count = m_count + 32'd1;
      end
    end else if (p_stall) begin
      if (done) begin
        held.push_back({m_pc ^ KEY, m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end else if (done) begin
      m_instr = m_pc ^ KEY; m_pc4 = m_pc + 32'd4; m_valid = 1;
      m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
    end else begin
      m_valid = 0; m_instr = NOP;
    end
  endtask

  // One clock: drive inputs, check the request side, then check registered outputs.
  task automatic cycle(input bit br, input logic [31:0] tgt, input bit stall, input bit ready);
    logic [31:0] old_count;
    Branch_Taken_In = br; Branch_Target_In = tgt; Stall_In = stall; IMem_Ready_In = ready;
    #1;
    p_req = m_started && (held.size() == 0) && !br;
    check_val("req", 32'(IMem_Req_Out), 32'(p_req));
    if (p_req) check_val("addr", IMem_Addr_Out, m_pc);
    p_br = br; p_tgt = tgt; p_stall = stall; p_ready = ready;
    @(posedge CLOCK); #1;
    old_count = m_count;
    model_edge();
    check_val("instr", Instruction_Out, m_instr);
    check_val("pc4", PCPlus4_Out, m_pc4);
    check_val("valid", 32'(Valid_Out), 32'(m_valid));
    check_val("count", Fetch_Count_Out, m_count);
    if (m_count != old_count)
      $display("deliver #%0d instr=%h pc4=%h", m_count, m_instr, m_pc4);
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
  task automatic apply_reset();
    #2;
    RESET_N = 1'b0;
    Branch_Taken_In = 1'b0; Stall_In = 1'b0; IMem_Ready_In = 1'b0;
    #1;
    model_reset();
    check_val("rst_instr", Instruction_Out, m_instr);
    check_val("rst_pc4", PCPlus4_Out, m_pc4);
    check_val("rst_valid", 32'(Valid_Out), 32'(m_valid));
    check_val("rst_count", Fetch_Count_Out, m_count);
    check_val("rst_req", 32'(IMem_Req_Out), 32'd0);
    @(posedge CLOCK);
    @(posedge CLOCK);
    #3;
    RESET_N = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  logic [31:0] saved_count;

  initial begin
    model_reset();
    @(posedge CLOCK); #1;

    // Back-to-back fetch after reset
    apply_reset();
    repeat (4) cycle(0, 32'd0, 0, 1);
    check_val("d30_count", Fetch_Count_Out, 32'd3);
    check_val("d30_pc4", PCPlus4_Out, 32'd12);
    check_val("d30_instr", Instruction_Out, 32'hA5A5A5AD);
    check_val("d30_valid", 32'(Valid_Out), 32'd1);

    // Memory ready every third cycle
    repeat (2) begin
      cycle(0, 32'd0, 0, 0);
      cycle(0, 32'd0, 0, 0);
      cycle(0, 32'd0, 0, 1);
    end

    // Stall while the word at 8 completes
    apply_reset();
    repeat (3) cycle(0, 32'd0, 0, 1);
    repeat (4) cycle(0, 32'd0, 1, 1);
    check_val("d32_hold_pc4", PCPlus4_Out, 32'd8);
    check_val("d32_hold_req", 32'(IMem_Req_Out), 32'd0);
    cycle(0, 32'd0, 0, 1);
    check_val("d32_instr", Instruction_Out, 32'hA5A5A5AD);
    check_val("d32_pc4", PCPlus4_Out, 32'd12);
    check_val("d32_next_addr", IMem_Addr_Out, 32'd12);

    // Redirect coincident with a ready fetch at 16
    apply_reset();
    repeat (5) cycle(0, 32'd0, 0, 1);
    cycle(1, 32'h00000103, 0, 1);
    check_val("d33_valid", 32'(Valid_Out), 32'd0);
    check_val("d33_count", Fetch_Count_Out, 32'd4);
    Branch_Taken_In = 1'b0; #1;
    check_val("d33_addr", IMem_Addr_Out, 32'h00000100);

    // Redirect while holding a stalled word
    cycle(0, 32'd0, 0, 1);
    cycle(0, 32'd0, 1, 1);
    cycle(0, 32'd0, 1, 1);
    saved_count = m_count;
    cycle(1, 32'h00000200, 1, 0);
    check_val("d34_count", Fetch_Count_Out, saved_count);
    check_val("d34_valid", 32'(Valid_Out), 32'd0);
    Branch_Taken_In = 1'b0; #1;
    check_val("d34_addr", IMem_Addr_Out, 32'h00000200);

    // Reset in the middle of a wait, then fetch at the top of the address space
    cycle(0, 32'd0, 0, 0);
    cycle(0, 32'd0, 0, 0);
    apply_reset();
    cycle(1, 32'hFFFFFFFF, 0, 0);
    cycle(0, 32'd0, 0, 1);
    check_val("d35_pc4", PCPlus4_Out, 32'd0);
    check_val("d35_instr", Instruction_Out, 32'h5A5A5A59);
    check_val("d35_addr", IMem_Addr_Out, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0)
        apply_reset();
      else
        cycle($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) == 0,
              1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
